si_socket_array: RTL and testbench

- Multi-socket successor of the single-socket UDT system-test socket responder model.
- Serves NUM_SOCK independent sockets through connect and close handshakes.
- Adds an optional peer-initiated close per socket, driven by an idle timer.
- All sockets share one valid/ready state-report channel, with a round-robin arbiter and a socket-id tag.
- Sits in the system testbench between the UDT core's socket-control interface and its state-write port.

---
 rtl/si_socket_array.sv | 179 +++++++++++++++++
 tb/tb_si_socket_array.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/si_socket_array.sv
// si_socket_array: multi-socket UDT system-test socket responder.
// Ports: per-socket connect/close/peer-close handshakes; one shared
// valid/ready state-report channel {state_valid, udt_state, state_sock_id}.
module si_socket_array #(
  parameter int NUM_SOCK = 4,
  parameter int STATE_W = 32,
  parameter logic [STATE_W-1:0] ST_CONNECTED = STATE_W'(32'h0000_0010),
  parameter logic [STATE_W-1:0] ST_CLOSED = STATE_W'(32'h0000_1000),
  parameter int TIMER_W = 16,
  parameter int PEER_CLOSE_CYCLES = 0,
  localparam int ID_W = (NUM_SOCK > 1) ? $clog2(NUM_SOCK) : 1
) (
  input  logic                core_clk,
  input  logic                core_rst_n,
  input  logic [NUM_SOCK-1:0] Req_Connect,
  output logic [NUM_SOCK-1:0] Res_Connect,
  input  logic [NUM_SOCK-1:0] Req_Close,
  output logic [NUM_SOCK-1:0] Res_Close,
  output logic [NUM_SOCK-1:0] Peer_Req_Close,
  input  logic [NUM_SOCK-1:0] Peer_Res_Close,
  input  logic                state_ready,
  output logic                state_valid,
  output logic [STATE_W-1:0]  udt_state,
  output logic [ID_W-1:0]     state_sock_id
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RES_CONN,
    S_REP_CONN,
    S_WAIT_CONN,
    S_CONNECTED,
    S_RES_CLOSE,
    S_PEER_REQ,
    S_REP_CLOSE,
    S_WAIT_CLOSE,
    S_CLOSE_WAIT
  } st_t;

  localparam bit PEER_EN = (PEER_CLOSE_CYCLES != 0);
  localparam logic [TIMER_W-1:0] PEER_LAST =
    TIMER_W'(PEER_CLOSE_CYCLES - 1);

  st_t                r_st  [NUM_SOCK];
  logic [TIMER_W-1:0] r_tmr [NUM_SOCK];
  logic [ID_W-1:0]    r_ptr;
  logic               r_valid;
  logic [STATE_W-1:0] r_state;
  logic [ID_W-1:0]    r_id;
  logic [NUM_SOCK-1:0] r_res_conn;
  logic [NUM_SOCK-1:0] r_res_close;
  logic [NUM_SOCK-1:0] r_peer_req;

  logic [NUM_SOCK-1:0] w_req;
  logic                w_gnt_vld;
  logic                w_gnt_cls;
  logic [ID_W-1:0]     w_gnt_id;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic                w_hs;
  logic                w_load;
  logic                w_take;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_SOCK; i++) begin
      w_req[i] = (r_st[i] == S_REP_CONN) ||
                 (r_st[i] == S_REP_CLOSE);
    end
  end

  // Round-robin: scan offsets from the far end down so the
  // requester closest at/after r_ptr is the last one written.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_cls = 1'b0;
    w_gnt_id  = '0;
    for (int j = NUM_SOCK - 1; j >= 0; j--) begin
      for (int i = 0; i < NUM_SOCK; i++) begin
        if (w_req[i] &&
            ((int'(r_ptr) + j == i) ||
             (int'(r_ptr) + j == i + NUM_SOCK))) begin
          w_gnt_vld = 1'b1;
          w_gnt_cls = (r_st[i] == S_REP_CLOSE);
          w_gnt_id  = ID_W'(i);
        end
      end
    end
  end

  assign w_ptr_nxt = (int'(w_gnt_id) == NUM_SOCK - 1) ?
                     '0 : w_gnt_id + 1'b1;
  assign w_hs   = r_valid & state_ready;
  // Output register refills on the same edge it is drained.
  assign w_load = ~r_valid | state_ready;
  assign w_take = w_load & w_gnt_vld;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      for (int i = 0; i < NUM_SOCK; i++) begin
        r_st[i]  <= S_IDLE;
        r_tmr[i] <= '0;
      end
      r_ptr       <= '0;
      r_valid     <= 1'b0;
      r_state     <= '0;
      r_id        <= '0;
      r_res_conn  <= '0;
      r_res_close <= '0;
      r_peer_req  <= '0;
    end else begin
      r_res_conn  <= '0;
      r_res_close <= '0;
      if (w_load) begin
        r_valid <= w_gnt_vld;
        if (w_gnt_vld) begin
          r_id    <= w_gnt_id;
          r_state <= w_gnt_cls ? ST_CLOSED : ST_CONNECTED;
        end
      end
      if (w_take) r_ptr <= w_ptr_nxt;
      for (int i = 0; i < NUM_SOCK; i++) begin
        unique case (r_st[i])
          S_IDLE: begin
            if (Req_Connect[i]) begin
              r_st[i]       <= S_RES_CONN;
              r_res_conn[i] <= 1'b1;
            end
          end
          S_RES_CONN: r_st[i] <= S_REP_CONN;
          S_REP_CONN: begin
            if (w_take && w_gnt_id == ID_W'(i))
              r_st[i] <= S_WAIT_CONN;
          end
          S_WAIT_CONN: begin
            if (w_hs && r_id == ID_W'(i)) begin
              r_st[i]  <= S_CONNECTED;
              r_tmr[i] <= '0;
            end
          end
          S_CONNECTED: begin
            if (r_tmr[i] != '1) r_tmr[i] <= r_tmr[i] + 1'b1;
            if (Req_Close[i]) begin
              r_st[i]        <= S_RES_CLOSE;
              r_res_close[i] <= 1'b1;
            end else if (PEER_EN && r_tmr[i] == PEER_LAST) begin
              r_st[i]       <= S_PEER_REQ;
              r_peer_req[i] <= 1'b1;
            end
          end
          S_RES_CLOSE: r_st[i] <= S_REP_CLOSE;
          S_PEER_REQ: begin
            if (Peer_Res_Close[i]) begin
              r_st[i]       <= S_REP_CLOSE;
              r_peer_req[i] <= 1'b0;
            end
          end
          S_REP_CLOSE: begin
            if (w_take && w_gnt_id == ID_W'(i))
              r_st[i] <= S_WAIT_CLOSE;
          end
          S_WAIT_CLOSE: begin
            if (w_hs && r_id == ID_W'(i))
              r_st[i] <= S_CLOSE_WAIT;
          end
          S_CLOSE_WAIT: r_st[i] <= S_IDLE;
          default: r_st[i] <= S_IDLE;
        endcase
      end
    end
  end

  assign Res_Connect    = r_res_conn;
  assign Res_Close      = r_res_close;
  assign Peer_Req_Close = r_peer_req;
  assign state_valid    = r_valid;
  assign udt_state      = r_state;
  assign state_sock_id  = r_id;

endmodule

// File: tb/tb_si_socket_array.sv
// tb_si_socket_array: directed scenarios plus a randomized run
// checked against a per-socket handshake-phase model.
module tb_si_socket_array;

  localparam logic [31:0] CONN = 32'h0000_0010;
  localparam logic [31:0] CLSD = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_conn, res_conn, req_close, res_close;
  logic [3:0]  peer_req, peer_res;
  logic        ready, valid;
  logic [31:0] st;
  logic [1:0]  sid;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  si_socket_array #(
    .NUM_SOCK(4),
    .PEER_CLOSE_CYCLES(8)
  ) dut (
    .core_clk(clk),
    .core_rst_n(rst_n),
    .Req_Connect(req_conn),
    .Res_Connect(res_conn),
    .Req_Close(req_close),
    .Res_Close(res_close),
    .Peer_Req_Close(peer_req),
    .Peer_Res_Close(peer_res),
    .state_ready(ready),
    .state_valid(valid),
    .udt_state(st),
    .state_sock_id(sid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_conn = '0; req_close = '0; peer_res = '0;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req_conn = '0; req_close = '0; peer_res = '0;
    ready = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (res_conn !== 4'h0)
      $display("FAIL rst_res_conn act=%h exp=0", res_conn);
    else n_pass++;
    n_chk++;
    if (res_close !== 4'h0)
      $display("FAIL rst_res_close act=%h exp=0", res_close);
    else n_pass++;
    n_chk++;
    if (peer_req !== 4'h0)
      $display("FAIL rst_peer_req act=%h exp=0", peer_req);
    else n_pass++;
    n_chk++;
    if ({valid, st, sid} !== 35'h0)
      $display("FAIL rst_report act=%b/%h/%0d exp=0",
               valid, st, sid);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_connect_latency();
    apply_reset();
    repeat (3) tick();
    req_conn = 4'b0100;
    tick();
    n_chk++;
    if ({res_conn, valid} !== {4'b0100, 1'b0})
      $display("FAIL lat_res act=%h/%b exp=4/0", res_conn, valid);
    else n_pass++;
    req_conn = '0;
    tick();
    n_chk++;
    if ({res_conn, valid} !== 5'b0)
      $display("FAIL lat_res_drop act=%h/%b exp=0/0",
               res_conn, valid);
    else n_pass++;
    tick();
    n_chk++;
    if ({valid, st, sid} !== {1'b1, CONN, 2'd2})
      $display("FAIL lat_report act=%b/%h/%0d exp=1/10/2",
               valid, st, sid);
    else n_pass++;
    tick();
    n_chk++;
    if (valid !== 1'b0)
      $display("FAIL lat_one_cycle act=%b exp=0", valid);
    else n_pass++;
  endtask

  task automatic test_all_connect();
    apply_reset();
    req_conn = 4'hF;
    tick();
    n_chk++;
    if (res_conn !== 4'hF)
      $display("FAIL all_res act=%h exp=f", res_conn);
    else n_pass++;
    req_conn = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_chk++;
      if ({valid, st, sid} !== {1'b1, CONN, 2'(k)})
        $display("FAIL all_rep%0d act=%b/%h/%0d exp=1/10/%0d",
                 k, valid, st, sid, k);
      else n_pass++;
    end
    tick();
    n_chk++;
    if (valid !== 1'b0)
      $display("FAIL all_drain act=%b exp=0", valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0]  hid [4];
    logic [31:0] hst [4];
    int          hc  [4];
    int          hn;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      hid[k] = '0; hst[k] = '0; hc[k] = 0;
    end
    hn = 0;
    ready = 1'b0;
    req_conn = 4'b1010;
    tick();
    req_conn = '0;
    tick();
    tick();
    n_chk++;
    if ({valid, st, sid} !== {1'b1, CONN, 2'd1})
      $display("FAIL bp_first act=%b/%h/%0d exp=1/10/1",
               valid, st, sid);
    else n_pass++;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_chk++;
      if ({valid, st, sid} !== {1'b1, CONN, 2'd1})
        $display("FAIL bp_hold%0d act=%b/%h/%0d exp=1/10/1",
                 k, valid, st, sid);
      else n_pass++;
    end
    ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (valid && hn < 4) begin
        hid[hn] = sid; hst[hn] = st; hc[hn] = k;
        hn++;
      end
      tick();
    end
    n_chk++;
    if (hn !== 2)
      $display("FAIL bp_count act=%0d exp=2", hn);
    else n_pass++;
    n_chk++;
    if ({hid[0], hid[1]} !== {2'd1, 2'd3})
      $display("FAIL bp_order act=%0d,%0d exp=1,3",
               hid[0], hid[1]);
    else n_pass++;
    n_chk++;
    if ({hst[0], hst[1]} !== {CONN, CONN})
      $display("FAIL bp_state act=%h,%h exp=10,10",
               hst[0], hst[1]);
    else n_pass++;
    n_chk++;
    if (hc[1] - hc[0] !== 1)
      $display("FAIL bp_bubble act=%0d exp=1", hc[1] - hc[0]);
    else n_pass++;
  endtask

  task automatic test_local_close();
    apply_reset();
    req_conn = 4'b0010;
    tick();
    req_conn = '0;
    req_close = 4'b0010;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_chk++;
      if (res_close !== 4'h0)
        $display("FAIL lc_ignore%0d act=%h exp=0", k, res_close);
      else n_pass++;
    end
    tick();
    n_chk++;
    if (res_close !== 4'b0010)
      $display("FAIL lc_res act=%h exp=2", res_close);
    else n_pass++;
    req_close = '0;
    tick();
    n_chk++;
    if (res_close !== 4'h0)
      $display("FAIL lc_res_drop act=%h exp=0", res_close);
    else n_pass++;
    tick();
    n_chk++;
    if ({valid, st, sid} !== {1'b1, CLSD, 2'd1})
      $display("FAIL lc_report act=%b/%h/%0d exp=1/1000/1",
               valid, st, sid);
    else n_pass++;
    tick();
    tick();
    req_conn = 4'b0010;
    tick();
    n_chk++;
    if (res_conn !== 4'b0010)
      $display("FAIL lc_reconn act=%h exp=2", res_conn);
    else n_pass++;
    req_conn = '0;
    tick();
    tick();
    n_chk++;
    if ({valid, st, sid, peer_req} !== {1'b1, CONN, 2'd1, 4'h0})
      $display("FAIL lc_rerep act=%b/%h/%0d/%h exp=1/10/1/0",
               valid, st, sid, peer_req);
    else n_pass++;
  endtask

  task automatic test_peer_close();
    apply_reset();
    req_conn = 4'b0001;
    tick();
    req_conn = '0;
    repeat (10) tick();
    n_chk++;
    if (peer_req !== 4'h0)
      $display("FAIL pc_early act=%h exp=0", peer_req);
    else n_pass++;
    tick();
    n_chk++;
    if (peer_req !== 4'b0001)
      $display("FAIL pc_rise act=%h exp=1", peer_req);
    else n_pass++;
    req_close = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_chk++;
      if ({peer_req, res_close} !== {4'b0001, 4'h0})
        $display("FAIL pc_hold%0d act=%h/%h exp=1/0",
                 k, peer_req, res_close);
      else n_pass++;
    end
    peer_res = 4'b0001;
    tick();
    n_chk++;
    if ({peer_req, res_close, valid} !== 9'h0)
      $display("FAIL pc_ack act=%h/%h/%b exp=0/0/0",
               peer_req, res_close, valid);
    else n_pass++;
    peer_res = '0;
    req_close = '0;
    tick();
    n_chk++;
    if ({valid, st, sid} !== {1'b1, CLSD, 2'd0})
      $display("FAIL pc_report act=%b/%h/%0d exp=1/1000/0",
               valid, st, sid);
    else n_pass++;
    // Local close on the expiry cycle beats the peer close.
    apply_reset();
    peer_res = 4'b0001;
    req_conn = 4'b0001;
    tick();
    req_conn = '0;
    repeat (10) tick();
    req_close = 4'b0001;
    tick();
    n_chk++;
    if ({res_close, peer_req} !== {4'b0001, 4'h0})
      $display("FAIL pc_race act=%h/%h exp=1/0",
               res_close, peer_req);
    else n_pass++;
    req_close = '0;
    tick();
    tick();
    n_chk++;
    if ({valid, st, sid} !== {1'b1, CLSD, 2'd0})
      $display("FAIL pc_race_rep act=%b/%h/%0d exp=1/1000/0",
               valid, st, sid);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_chk++;
      if (peer_req !== 4'h0)
        $display("FAIL pc_race_peer%0d act=%h exp=0", k, peer_req);
      else n_pass++;
    end
    peer_res = '0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_conn = 4'b1000;
    tick();
    req_conn = '0;
    repeat (3) tick();
    ready = 1'b0;
    tick();
    req_conn = 4'b0001;
    tick();
    req_conn = '0;
    repeat (6) tick();
    n_chk++;
    if ({valid, peer_req} !== {1'b1, 4'b1000})
      $display("FAIL rm_pre act=%b/%h exp=1/8", valid, peer_req);
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({res_conn, res_close, peer_req} !== 12'h0)
      $display("FAIL rm_hs act=%h/%h/%h exp=0",
               res_conn, res_close, peer_req);
    else n_pass++;
    n_chk++;
    if ({valid, st, sid} !== 35'h0)
      $display("FAIL rm_report act=%b/%h/%0d exp=0",
               valid, st, sid);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    req_conn = 4'b1000;
    tick();
    n_chk++;
    if (res_conn !== 4'b1000)
      $display("FAIL rm_reconn act=%h exp=8", res_conn);
    else n_pass++;
    req_conn = '0;
    tick();
    tick();
    n_chk++;
    if ({valid, st, sid} !== {1'b1, CONN, 2'd3})
      $display("FAIL rm_rerep act=%b/%h/%0d exp=1/10/3",
               valid, st, sid);
    else n_pass++;
  endtask

  // Phases: 0 idle, 1 connect report due, 2 connected,
  // 3 close report due, 4 peer close held, 5 close report due.
  task automatic test_random();
    int          ph [4];
    int          ct [4];
    logic [3:0]  pc, pcl, ppr, ppeer;
    logic        stall;
    logic [34:0] held;
    int          id;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      ph[i] = 0; ct[i] = 0;
    end
    pc = '0; pcl = '0; ppr = '0; ppeer = '0;
    stall = 1'b0; held = '0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      req_conn = 4'($urandom);
      for (int b = 0; b < 4; b++) begin
        req_close[b] = ($urandom_range(0, 7) == 0);
        peer_res[b]  = ($urandom_range(0, 3) == 0);
      end
      ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (stall) begin
        n_chk++;
        if ({valid, st, sid} !== held)
          $display("FAIL rnd_stable c=%0d act=%h exp=%h",
                   c, {valid, st, sid}, held);
        else n_pass++;
      end
      for (int i = 0; i < 4; i++) begin
        if (res_conn[i]) begin
          n_chk++;
          if (!(ph[i] == 0 && pc[i]))
            $display("FAIL rnd_conn s%0d c=%0d ph=%0d req=%b",
                     i, c, ph[i], pc[i]);
          else n_pass++;
          ph[i] = 1;
        end
        if (res_close[i]) begin
          n_chk++;
          if (!(ph[i] == 2 && pcl[i] &&
                c - ct[i] >= 2 && c - ct[i] <= 9))
            $display("FAIL rnd_close s%0d c=%0d ph=%0d dt=%0d",
                     i, c, ph[i], c - ct[i]);
          else n_pass++;
          ph[i] = 3;
        end
        if (peer_req[i] && !ppeer[i]) begin
          n_chk++;
          if (!(ph[i] == 2 && c - ct[i] == 9))
            $display("FAIL rnd_peer s%0d c=%0d ph=%0d dt=%0d",
                     i, c, ph[i], c - ct[i]);
          else n_pass++;
          ph[i] = 4;
        end
        if (!peer_req[i] && ppeer[i]) begin
          n_chk++;
          if (!(ph[i] == 4 && ppr[i]))
            $display("FAIL rnd_peer_ack s%0d c=%0d ph=%0d ack=%b",
                     i, c, ph[i], ppr[i]);
          else n_pass++;
          ph[i] = 5;
        end
        if (ph[i] == 2 && c - ct[i] == 10) begin
          n_chk++;
          $display("FAIL rnd_no_close s%0d c=%0d act=none exp=close",
                   i, c);
        end
      end
      if (valid && ready) begin
        id = int'(sid);
        n_chk++;
        if (st === CONN && ph[id] == 1) begin
          n_pass++;
          ph[id] = 2;
          ct[id] = c;
        end else if (st === CLSD && (ph[id] == 3 || ph[id] == 5)) begin
          n_pass++;
          ph[id] = 0;
        end else
          $display("FAIL rnd_report s%0d c=%0d act=%h ph=%0d",
                   id, c, st, ph[id]);
      end
      stall = valid && !ready;
      held  = {valid, st, sid};
      pc = req_conn; pcl = req_close;
      ppr = peer_res; ppeer = peer_req;
    end
    @(posedge clk);
    #1;
    req_conn = '0; req_close = '0; peer_res = '0;
    ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_connect_latency();
    test_all_connect();
    test_back_to_back();
    test_local_close();
    test_peer_close();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
